pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//   Central stall/flush sequencer for the 5-stage MIPS pipeline. Drives the enable
//   and flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC.
//   The EX/MEM flush output connects to that register's synchronous clear input.
//   Sources: load-use hazards, taken branches resolved in MEM, and a multi-cycle
//   data-memory handshake with timeout.
// PARAMETERS
//   REG_W        5    register-index width
//   MEM_TIMEOUT  15   max MWAIT cycles without mem_ack before error (>=1)
//   CNT_W        16   width of stall statistics counter
// PORTS
//   clk          in   1      rising-edge clock
//   Reset        in   1      asynchronous, active-high reset
//   id_rs        in   REG_W  rs index of instr in ID
//   id_rt        in   REG_W  rt index of instr in ID
//   ex_memread   in   1      instr in EX is a load
//   ex_rt        in   REG_W  load destination index in EX
//   br_taken     in   1      branch in MEM resolved taken
//   mem_req      in   1      instr in MEM accesses data memory
//   mem_ack      in   1      data memory completes access this cycle
//   pc_en        out  1      PC load enable
//   ifid_en      out  1      IF/ID load enable
//   idex_en      out  1      ID/EX load enable
//   exmem_en     out  1      EX/MEM load enable
//   ifid_flush   out  1      clear IF/ID
//   idex_flush   out  1      clear ID/EX (bubble insert)
//   exmem_flush  out  1      clear EX/MEM
//   mem_err      out  1      sticky data-memory timeout flag
//   stall_cnt    out  CNT_W  cycles with pc_en==0, saturating
// BEHAVIOUR
//   Reset high (async): state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0.
//     While Reset=1: all *_en=0, all *_flush=1.
//   load_use = ex_memread & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt).
//   mem_hold = mem_req & ~mem_ack.
//   Outputs are combinational from state and inputs; zero latency.
//   Defaults: all *_en=1, all *_flush=0.
//   FSM states: RUN, MWAIT, MERR.
//   RUN, priority high->low:
//     mem_hold: all *_en=0, no flush. Next state MWAIT, wait_cnt<=0.
//     br_taken: pc_en=1; ifid/idex/exmem_flush=1. Stay RUN.
//     load_use: pc_en=0, ifid_en=0, idex_flush=1. Stay RUN.
//     else: defaults. Stay RUN.
//   MWAIT:
//     mem_ack=0: all *_en=0, no flush.
//       wait_cnt==MEM_TIMEOUT-1 -> MERR; else wait_cnt<=wait_cnt+1.
//     mem_ack=1: evaluated as RUN with mem_hold=0 (br_taken/load_use priority).
//       Next state RUN, wait_cnt<=0.
//   MERR: all *_en=0, no flush, mem_err=1. Leaves only via Reset.
//   Total freeze before MERR = MEM_TIMEOUT+1 cycles.
//   ex_rt==0 never stalls. br_taken wins over simultaneous load_use
//     (the offending instr is flushed).
//   stall_cnt increments each cycle pc_en==0 (Reset excluded); holds at 2^CNT_W-1.
//   Reset mid-MWAIT: immediate return to RUN; the pending access is abandoned.
// TESTING
//   1 lw r8 in EX (ex_memread=1, ex_rt=8), id_rs=8 -> 1 cycle pc_en=0, ifid_en=0,
//     idex_flush=1; stall_cnt=1.
//   2 ex_rt=0, id_rs=0, ex_memread=1 -> no stall, all en=1.
//   3 br_taken=1 with load_use=1 -> pc_en=1; ifid/idex/exmem_flush=1; stall_cnt unchanged.
//   4 mem_req=1, ack after 3 cycles -> en=0 for 3 cycles, ack cycle en=1, state RUN, stall_cnt=3.
//   5 mem_req=1, ack never -> mem_err=1 after edge 16; all en=0 until Reset.
//   6 Reset pulse while in MWAIT (cycle 2) -> flushes=1 during Reset, RUN after; mem_err=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage MIPS pipeline.
// Arbitrates between data-memory wait states, taken branches resolved in MEM,
// and load-use hazards. It drives the PC and the pipeline-register enables and
// flushes, flags a sticky memory timeout and counts stalled cycles.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_W       = 5,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    // The wait counter only has to reach MEM_TIMEOUT-1.
    localparam int unsigned WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MWAIT = 2'd1,
        ST_MERR  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic mem_hold;
    logic run_eval;

    assign load_use = ex_memread && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign mem_hold = mem_req && !mem_ack;

    // Next-state and control outputs; Reset overrides everything to a full flush.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        mem_err     = 1'b0;
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        run_eval    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_hold) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_en    = 1'b0;
                    exmem_en   = 1'b0;
                    state_d    = ST_MWAIT;
                    wait_cnt_d = '0;
                end else begin
                    run_eval = 1'b1;
                end
            end
            ST_MWAIT: begin
                if (!mem_ack) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    if (wait_cnt_q == WC_LAST) begin
                        state_d = ST_MERR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WC_W'(1);
                    end
                end else begin
                    // Completion cycle is resolved exactly like a RUN cycle
                    // with no pending memory hold.
                    run_eval   = 1'b1;
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            ST_MERR: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                mem_err  = 1'b1;
            end
            default: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                state_d  = ST_RUN;
            end
        endcase

        // A taken branch squashes the load-use victim, so it takes priority.
        if (run_eval) begin
            if (br_taken) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end

        if (Reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            mem_err     = 1'b0;
        end
    end

    // Saturating count of cycles in which the PC is held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State, wait counter and statistics registers.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: constant vector table, hand-written
// multi-cycle sequences and random stimulus against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned REG_W       = 5;
    localparam int unsigned MEM_TIMEOUT = 15;
    localparam int unsigned CNT_W       = 5;   // small so saturation is reachable
    localparam int          CNT_MAX     = (1 << CNT_W) - 1;

    // Output vector order: pc, ifid, idex, exmem enables; ifid, idex, exmem flushes; mem_err
    localparam logic [7:0] V_NORM   = 8'hF0;
    localparam logic [7:0] V_LU     = 8'h34;
    localparam logic [7:0] V_BR     = 8'hFE;
    localparam logic [7:0] V_FREEZE = 8'h00;
    localparam logic [7:0] V_ERR    = 8'h01;
    localparam logic [7:0] V_RESET  = 8'h0E;

    logic             clk = 1'b0;
    logic             Reset;
    logic [REG_W-1:0] id_rs, id_rt, ex_rt;
    logic             ex_memread, br_taken, mem_req, mem_ack;
    logic             pc_en, ifid_en, idex_en, exmem_en;
    logic             ifid_flush, idex_flush, exmem_flush, mem_err;
    logic [CNT_W-1:0] stall_cnt;

    pipe_hazard_ctrl #(
        .REG_W      (REG_W),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .br_taken   (br_taken),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .pc_en      (pc_en),
        .ifid_en    (ifid_en),
        .idex_en    (idex_en),
        .exmem_en   (exmem_en),
        .ifid_flush (ifid_flush),
        .idex_flush (idex_flush),
        .exmem_flush(exmem_flush),
        .mem_err    (mem_err),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: whether an access is outstanding, how many cycles it has frozen
    // the pipe, whether the timeout fired, and total stalled cycles.
    bit m_pending;
    bit m_err;
    int m_frozen;
    int m_stalls;

    typedef struct {
        logic             memread;
        logic [REG_W-1:0] ex_rt;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             br;
        logic             req;
        logic             ack;
        logic [7:0]       exp;
    } vec_t;

    function automatic logic [7:0] dut_vec();
        return {pc_en, ifid_en, idex_en, exmem_en,
                ifid_flush, idex_flush, exmem_flush, mem_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic mr, input logic [REG_W-1:0] xrt,
                          input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                          input logic br, input logic req, input logic ack);
        ex_memread = mr; ex_rt = xrt; id_rs = rs; id_rt = rt;
        br_taken = br; mem_req = req; mem_ack = ack;
    endtask

    // One clock cycle with the current inputs: compare at negedge, advance model.
    task automatic step(input string name, output logic [7:0] seen);
        logic [7:0] exp;
        bit lu, hold;
        @(negedge clk);
        lu   = ex_memread && (ex_rt != 0) && (ex_rt == id_rs || ex_rt == id_rt);
        hold = mem_req && !mem_ack;
        if (m_err)                     exp = V_ERR;
        else if (m_pending && !mem_ack) exp = V_FREEZE;
        else if (!m_pending && hold)   exp = V_FREEZE;
        else if (br_taken)             exp = V_BR;
        else if (lu)                   exp = V_LU;
        else                           exp = V_NORM;
        seen = dut_vec();
        check({name, ".out"}, 32'(seen), 32'(exp));
        check({name, ".cnt"}, 32'(stall_cnt), 32'(m_stalls));
        if (!exp[7] && m_stalls < CNT_MAX) m_stalls++;
        if (!m_err) begin
            if (m_pending) begin
                if (mem_ack) m_pending = 1'b0;
                else begin
                    m_frozen++;
                    if (m_frozen == MEM_TIMEOUT + 1) m_err = 1'b1;
                end
            end else if (hold) begin
                m_pending = 1'b1;
                m_frozen  = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string name);
        Reset = 1'b1;
        @(negedge clk);
        check({name, ".rst_out"}, 32'(dut_vec()), 32'(V_RESET));
        check({name, ".rst_cnt"}, 32'(stall_cnt), 32'd0);
        m_pending = 1'b0; m_err = 1'b0; m_frozen = 0; m_stalls = 0;
        @(posedge clk);
        #1;
        Reset = 1'b0;
    endtask

    vec_t tbl[10];
    logic [7:0] seen;

    initial begin
        tbl[0] = '{1'b1, 5'd8,  5'd8,  5'd0, 1'b0, 1'b0, 1'b0, V_LU};
        tbl[1] = '{1'b1, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, V_NORM};
        tbl[2] = '{1'b1, 5'd8,  5'd3,  5'd8, 1'b1, 1'b0, 1'b0, V_BR};
        tbl[3] = '{1'b1, 5'd8,  5'd3,  5'd8, 1'b0, 1'b0, 1'b0, V_LU};
        tbl[4] = '{1'b0, 5'd8,  5'd8,  5'd8, 1'b0, 1'b0, 1'b0, V_NORM};
        tbl[5] = '{1'b1, 5'd9,  5'd8,  5'd7, 1'b0, 1'b0, 1'b0, V_NORM};
        tbl[6] = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b1, 1'b0, 1'b0, V_BR};
        tbl[7] = '{1'b1, 5'd5,  5'd5,  5'd5, 1'b0, 1'b1, 1'b1, V_LU};
        tbl[8] = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b1, V_NORM};
        tbl[9] = '{1'b1, 5'd31, 5'd31, 5'd2, 1'b0, 1'b0, 1'b0, V_LU};

        set_in(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        Reset = 1'b0;
        #1;
        do_reset("init");

        // Single-cycle decisions from RUN
        foreach (tbl[i]) begin
            set_in(tbl[i].memread, tbl[i].ex_rt, tbl[i].rs, tbl[i].rt,
                   tbl[i].br, tbl[i].req, tbl[i].ack);
            step($sformatf("tbl%0d", i), seen);
            check($sformatf("tbl%0d.const", i), 32'(seen), 32'(tbl[i].exp));
        end

        // Load-use stalls exactly one cycle and counts it
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        do_reset("t1");
        set_in(1'b1, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0, 1'b0);
        step("t1.lu", seen);
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        step("t1.after", seen);
        check("t1.stall_cnt", 32'(stall_cnt), 32'd1);

        // Branch beats load-use; no stall counted
        set_in(1'b1, 5'd8, 5'd8, 5'd1, 1'b1, 1'b0, 1'b0);
        step("t3.br_lu", seen);
        check("t3.stall_cnt", 32'(stall_cnt), 32'd1);

        // Ack after three frozen cycles
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        do_reset("t4");
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) step($sformatf("t4.wait%0d", i), seen);
        mem_ack = 1'b1;
        step("t4.ack", seen);
        check("t4.ack_en", 32'(seen[7:4]), 32'hF);
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        step("t4.run", seen);
        check("t4.stall_cnt", 32'(stall_cnt), 32'd3);

        // Timeout: error after edge MEM_TIMEOUT+1, sticky, counter saturates
        do_reset("t5");
        mem_req = 1'b1;
        for (int i = 0; i < MEM_TIMEOUT + 1; i++) begin
            step($sformatf("t5.frz%0d", i), seen);
            if (i == MEM_TIMEOUT - 1) check("t5.err_early", 32'(mem_err), 32'd0);
        end
        check("t5.err", 32'(mem_err), 32'd1);
        mem_ack = 1'b1;
        for (int i = 0; i < 20; i++) step($sformatf("t5.stuck%0d", i), seen);
        check("t5.err_sticky", 32'(mem_err), 32'd1);
        check("t5.sat", 32'(stall_cnt), 32'(CNT_MAX));

        // Reset during MWAIT abandons the access
        do_reset("t6a");
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        step("t6.hold", seen);
        step("t6.wait", seen);
        do_reset("t6b");
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        step("t6.run", seen);
        check("t6.run_const", 32'(seen), 32'(V_NORM));

        // Random traffic against the model
        for (int blk = 0; blk < 10; blk++) begin
            do_reset($sformatf("rnd%0d", blk));
            for (int c = 0; c < 200; c++) begin
                set_in(1'(($urandom_range(0, 2) != 0)),
                       REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
                       REG_W'($urandom_range(0, 3)),
                       1'(($urandom_range(0, 7) == 0)),
                       1'(($urandom_range(0, 3) == 0)),
                       1'((blk >= 8) ? ($urandom_range(0, 15) == 0)
                                     : ($urandom_range(0, 1) == 0)));
                step($sformatf("rnd%0d.c%0d", blk, c), seen);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
